// File: rtl/decoder_sequencer_pkg.sv
// Shared definitions for the sequenced fixed-point decoder: default sizes,
// fixed-point format constants, FSM state encoding and a counter-width helper.
package decoder_sequencer_pkg;

  // Default geometry and word format (signed Q16.16 in a 32-bit word).
  localparam int N_INPUT_DEF  = 2;
  localparam int M_OUTPUT_DEF = 9;
  localparam int BITSIZE_DEF  = 32;
  localparam int FRAC_BITS    = 16;

  // Handy fixed-point constants for stimulus.
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h0001_0000;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_BIAS = 2'd2,
    ST_DONE = 2'd3
  } dec_state_e;

  // Width of a counter that must reach bound-1; never narrower than one bit.
  function automatic int cnt_width(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/decoder_mac_unit.sv
// Combinational datapath of the sequenced decoder: one multiplier feeding the
// accumulate adder, plus a separate adder for the final bias term.
module decoder_mac_unit #(
  parameter int BITSIZE   = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic [BITSIZE-1:0] z_word,
  input  logic [BITSIZE-1:0] w_word,
  input  logic [BITSIZE-1:0] acc,
  input  logic [BITSIZE-1:0] bias,
  output logic [BITSIZE-1:0] product,
  output logic [BITSIZE-1:0] acc_plus_product,
  output logic [BITSIZE-1:0] acc_plus_bias
);

  fixed_point_multiply #(
    .BITSIZE  (BITSIZE),
    .FRAC_BITS(FRAC_BITS)
  ) u_mul (
    .a(z_word),
    .b(w_word),
    .y(product)
  );

  fixed_point_add #(
    .BITSIZE(BITSIZE)
  ) u_mac_add (
    .a(acc),
    .b(product),
    .y(acc_plus_product)
  );

  fixed_point_add #(
    .BITSIZE(BITSIZE)
  ) u_bias_add (
    .a(acc),
    .b(bias),
    .y(acc_plus_bias)
  );

endmodule

// File: rtl/fixed_point_add.sv
// Signed fixed-point add with saturation on overflow (no wrap-around).
module fixed_point_add #(
  parameter int BITSIZE = 32
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] y
);

  logic [BITSIZE:0] sum_s;

  // One guard bit detects overflow; clamp toward the sign of the true sum.
  always_comb begin
    sum_s = {a[BITSIZE-1], a} + {b[BITSIZE-1], b};
    if (sum_s[BITSIZE] != sum_s[BITSIZE-1]) begin
      if (sum_s[BITSIZE]) begin
        y = {1'b1, {(BITSIZE-1){1'b0}}};
      end else begin
        y = {1'b0, {(BITSIZE-1){1'b1}}};
      end
    end else begin
      y = sum_s[BITSIZE-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_multiply.sv
// Signed fixed-point multiply: full-precision product, arithmetic shift right
// by the fraction width (truncation toward minus infinity), then saturation.
module fixed_point_multiply #(
  parameter int BITSIZE   = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] y
);

  localparam logic signed [2*BITSIZE-1:0] MAX_S = {{(BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [2*BITSIZE-1:0] MIN_S = {{(BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  logic signed [2*BITSIZE-1:0] full_s;
  logic signed [2*BITSIZE-1:0] shifted_s;

  // Multiply in double width, rescale, and clamp to the representable range.
  always_comb begin
    full_s    = $signed({{BITSIZE{a[BITSIZE-1]}}, a}) * $signed({{BITSIZE{b[BITSIZE-1]}}, b});
    shifted_s = full_s >>> FRAC_BITS;
    if (shifted_s > MAX_S) begin
      y = MAX_S[BITSIZE-1:0];
    end else if (shifted_s < MIN_S) begin
      y = MIN_S[BITSIZE-1:0];
    end else begin
      y = shifted_s[BITSIZE-1:0];
    end
  end

endmodule

// File: rtl/decoder_sequencer.sv
// Time-multiplexed fixed-point decoder layer: out[j] = sum_i z[i]*w[j][i] + b[j],
// computed one product per cycle with a shared multiplier/adder pair.
module decoder_sequencer
  import decoder_sequencer_pkg::*;
#(
  parameter int N_input  = N_INPUT_DEF,
  parameter int M_output = M_OUTPUT_DEF,
  parameter int BITSIZE  = BITSIZE_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_input*BITSIZE-1:0]          z,
  input  logic [N_input*M_output*BITSIZE-1:0] w,
  input  logic [M_output*BITSIZE-1:0]         b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [M_output*BITSIZE-1:0]    out,
  output logic                           busy
);

  localparam int I_W = cnt_width(N_input);
  localparam int J_W = cnt_width(M_output);
  localparam logic [I_W-1:0] I_LAST = I_W'(N_input - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(M_output - 1);

  dec_state_e                          state_q, state_d;
  logic [I_W-1:0]                      i_q, i_d;
  logic [J_W-1:0]                      j_q, j_d;
  logic [BITSIZE-1:0]                  acc_q, acc_d;
  logic [N_input*BITSIZE-1:0]          z_q, z_d;
  logic [N_input*M_output*BITSIZE-1:0] w_q, w_d;
  logic [M_output*BITSIZE-1:0]         b_q, b_d;
  logic [M_output*BITSIZE-1:0]         out_q, out_d;
  logic                                in_ready_q, in_ready_d;
  logic                                out_valid_q, out_valid_d;
  logic                                busy_q, busy_d;

  logic [BITSIZE-1:0] z_sel_s, w_sel_s, b_sel_s;
  logic [BITSIZE-1:0] product_s, acc_plus_product_s, acc_plus_bias_s;

  // Pick the operand words for the current (i, j) from the latched vectors.
  always_comb begin
    z_sel_s = z_q[int'(i_q)*BITSIZE +: BITSIZE];
    w_sel_s = w_q[(int'(j_q)*N_input + int'(i_q))*BITSIZE +: BITSIZE];
    b_sel_s = b_q[int'(j_q)*BITSIZE +: BITSIZE];
  end

  decoder_mac_unit #(
    .BITSIZE  (BITSIZE),
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .z_word          (z_sel_s),
    .w_word          (w_sel_s),
    .acc             (acc_q),
    .bias            (b_sel_s),
    .product         (product_s),
    .acc_plus_product(acc_plus_product_s),
    .acc_plus_bias   (acc_plus_bias_s)
  );

  // Next-state, datapath updates and next handshake flags.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    z_d     = z_q;
    w_d     = w_q;
    b_d     = b_q;
    out_d   = out_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          z_d     = z;
          w_d     = w;
          b_d     = b;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        // First term seeds the accumulator so left-to-right order is kept.
        if (i_q == '0) begin
          acc_d = product_s;
        end else begin
          acc_d = acc_plus_product_s;
        end
        if (i_q == I_LAST) begin
          state_d = ST_BIAS;
        end else begin
          i_d = i_q + I_W'(1);
        end
      end
      ST_BIAS: begin
        out_d[int'(j_q)*BITSIZE +: BITSIZE] = acc_plus_bias_s;
        i_d = '0;
        if (j_q == J_LAST) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + J_W'(1);
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flags are registered from the next state so they line up with it.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and flag registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      z_q         <= '0;
      w_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      w_q         <= w_d;
      b_q         <= b_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;

endmodule

// File: tb/tb_decoder_sequencer.sv
// Bench for decoder_sequencer: directed and random vectors checked against a
// behavioural Q16.16 model of the parallel decoder layer.
module tb_decoder_sequencer;
  import decoder_sequencer_pkg::*;

  localparam int N = 2;
  localparam int M = 9;
  localparam int W = 32;
  localparam int LAT = M * (N + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   z;
  logic [N*M*W-1:0] w;
  logic [M*W-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [M*W-1:0]   out;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] zv[N];
  logic [W-1:0] wv[N*M];
  logic [W-1:0] bv[M];
  logic [W-1:0] expv[M];

  decoder_sequencer #(.N_input(N), .M_output(M), .BITSIZE(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .z        (z),
    .w        (w),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ---- reference model: plain integer arithmetic on real values * 2^16 ----
  function automatic logic [W-1:0] clamp32(input longint v);
    longint c;
    c = v;
    if (c > 64'sd2147483647) c = 64'sd2147483647;
    if (c < -64'sd2147483648) c = -64'sd2147483648;
    return c[W-1:0];
  endfunction

  function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] c);
    longint p;
    p = longint'($signed(a)) * longint'($signed(c));
    p = p >>> 16;
    return clamp32(p);
  endfunction

  function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] c);
    return clamp32(longint'($signed(a)) + longint'($signed(c)));
  endfunction

  task automatic compute_exp();
    logic [W-1:0] acc;
    for (int j = 0; j < M; j++) begin
      acc = fp_mul(zv[0], wv[j*N]);
      for (int i = 1; i < N; i++) acc = fp_add(acc, fp_mul(zv[i], wv[j*N+i]));
      expv[j] = fp_add(acc, bv[j]);
    end
  endtask

  function automatic logic [W-1:0] rand_fp();
    logic [W-1:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0: r = {{12{r[19]}}, r[19:0]};
      1: r = {{8{r[23]}}, r[23:0]};
      default: r = r;
    endcase
    return r;
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) zv[i] = rand_fp();
    for (int k = 0; k < N*M; k++) wv[k] = rand_fp();
    for (int j = 0; j < M; j++) bv[j] = rand_fp();
  endtask

  task automatic drive_operands();
    for (int i = 0; i < N; i++) z[i*W +: W] = zv[i];
    for (int k = 0; k < N*M; k++) w[k*W +: W] = wv[k];
    for (int j = 0; j < M; j++) b[j*W +: W] = bv[j];
  endtask

  task automatic junk_inputs();
    for (int i = 0; i < N; i++) z[i*W +: W] = $urandom;
    for (int k = 0; k < N*M; k++) w[k*W +: W] = $urandom;
    for (int j = 0; j < M; j++) b[j*W +: W] = $urandom;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    for (int j = 0; j < M; j++) check(tag, out[j*W +: W], expv[j]);
  endtask

  // Wait (bounded) for out_valid after an accept; checks latency and busy.
  task automatic wait_done(input bit junk);
    int  cyc;
    bit  busy_ok;
    cyc = 0;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (junk) junk_inputs();
      step();
      cyc++;
    end
    check("latency", W'(cyc), W'(LAT));
    check("busy_during_run", {31'd0, busy_ok}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_in_ready();
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 10) begin
      step();
      cyc++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
  endtask

  // One full transaction with the current zv/wv/bv and a random output stall.
  task automatic run_vector(input int stall_max, input bit junk);
    int stalls;
    compute_exp();
    wait_in_ready();
    drive_operands();
    in_valid = 1'b1;
    step();
    check("in_ready_drop", {31'd0, in_ready}, 32'd0);
    in_valid = junk;
    wait_done(junk);
    check_outputs("result");
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stalls = $urandom_range(0, stall_max);
    repeat (stalls) step();
    check("valid_held", {31'd0, out_valid}, 32'd1);
    check_outputs("stall_hold");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("out_retained", out[(M-1)*W +: W], expv[M-1]);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    z = '0;
    w = '0;
    b = '0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    for (int j = 0; j < M; j++) check("rst_out", out[j*W +: W], 32'd0);
    step();
    rst = 1'b0;
    step();

    // Identity weights: every output is 1.0 + 2.0 = 3.0.
    zv[0] = FP_ONE;
    zv[1] = 32'h0002_0000;
    for (int k = 0; k < N*M; k++) wv[k] = FP_ONE;
    for (int j = 0; j < M; j++) bv[j] = FP_ZERO;
    run_vector(3, 1'b0);
    for (int j = 0; j < M; j++) check("identity_3p0", out[j*W +: W], 32'h0003_0000);

    // Packing order: out[j] = j + 0.5.
    zv[0] = FP_ONE;
    zv[1] = FP_ZERO;
    for (int j = 0; j < M; j++) begin
      wv[j*N]   = W'(j) << 16;
      wv[j*N+1] = W'($urandom);
      bv[j]     = 32'h0000_8000;
    end
    run_vector(2, 1'b0);
    for (int j = 0; j < M; j++) check("packing", out[j*W +: W], (W'(j) << 16) | 32'h0000_8000);

    // Saturation: positive overflow must clamp, never wrap.
    zv[0] = 32'h7FFF_FFFF;
    zv[1] = 32'h7FFF_FFFF;
    for (int k = 0; k < N*M; k++) wv[k] = FP_ONE;
    for (int j = 0; j < M; j++) bv[j] = 32'h7FFF_FFFF;
    run_vector(2, 1'b0);
    for (int j = 0; j < M; j++) check("saturate", out[j*W +: W], 32'h7FFF_FFFF);

    // Reset mid-computation clears everything asynchronously.
    randomize_ops();
    drive_operands();
    wait_in_ready();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int j = 0; j < M; j++) check("midrst_out", out[j*W +: W], 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    randomize_ops();
    run_vector(2, 1'b0);

    // Back-to-back with in_valid held high and changing data.
    randomize_ops();
    compute_exp();
    drive_operands();
    in_valid = 1'b1;
    step();
    check("b2b_first_accept", {31'd0, in_ready}, 32'd0);
    wait_done(1'b1);
    check_outputs("b2b_first");
    randomize_ops();
    compute_exp();
    out_ready = 1'b1;
    step();
    check("b2b_handoff_ready", {31'd0, in_ready}, 32'd1);
    drive_operands();
    out_ready = 1'b0;
    step();
    check("b2b_second_accept", {31'd0, in_ready}, 32'd0);
    wait_done(1'b1);
    check_outputs("b2b_second");
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Random golden comparisons with random output stalls and ignored junk.
    for (int v = 0; v < 200; v++) begin
      randomize_ops();
      run_vector(4, v[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
